booth_r4_mul_iter: RTL and testbench

- Iterative radix-4 Booth multiplier for the CPU EX-stage mul/mulh/mulh.u path.
- Generalises the fixed 32-bit unsigned AND-array partial-product generator:
  - operand width is a parameter;
  - signed and unsigned modes are supported;
  - one Booth digit is retired per cycle into an accumulator;
  - a valid/ready handshake is provided on both sides.
- Accepts one operation at a time, holds the full 2*WIDTH product until consumed, and supports a pipeline flush.

---
 rtl/mul_pkg.sv | 35 +++
 rtl/booth_r4_mul_iter_digit_sel.sv | 29 ++
 rtl/booth_r4_mul_iter.sv | 122 ++++++++++++
 tb/tb_booth_r4_mul_iter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types for the iterative radix-4 Booth multiplier: FSM states, Booth digit
// encoding and the digit-counter width helper.
package mul_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_dig_t;

  function automatic int unsigned cnt_width(int unsigned ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

  // Bits are {b[2i+1], b[2i], b[2i-1]}; 3'b111 is -0 and is encoded as plain zero.
  function automatic booth_dig_t booth_enc(logic [2:0] bits);
    booth_dig_t dig;
    dig = '0;
    unique case (bits)
      3'b001, 3'b010: dig.one = 1'b1;
      3'b011:         dig.two = 1'b1;
      3'b100:         begin dig.neg = 1'b1; dig.two = 1'b1; end
      3'b101, 3'b110: begin dig.neg = 1'b1; dig.one = 1'b1; end
      default:        dig = '0;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth_r4_mul_iter_digit_sel.sv
// Booth radix-4 partial-product selector: picks 0, +-A or +-2A; negation is
// one's complement here plus the carry-in returned alongside.
module booth_r4_digit_sel
  import mul_pkg::*;
#(
  parameter int unsigned PW = 64
) (
  input  logic [2:0]    bits_i,
  input  logic [PW-1:0] mcand_i,
  output logic [PW-1:0] pp_o,
  output logic          cin_o
);

  booth_dig_t  dig;
  logic [PW-1:0] mag;

  always_comb begin
    dig = booth_enc(bits_i);
    mag = '0;
    if (dig.one) begin
      mag = mcand_i;
    end else if (dig.two) begin
      mag = {mcand_i[PW-2:0], 1'b0};
    end
    pp_o  = dig.neg ? ~mag : mag;
    cin_o = dig.neg;
  end

endmodule

// File: rtl/booth_r4_mul_iter.sv
// Iterative radix-4 Booth multiplier, one digit per cycle, valid/ready on both sides.
// Optional macro MUL_EARLY_TERM_EN: finish as soon as all remaining digits are zero.
module booth_r4_mul_iter
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               op_signed,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               busy
);

  localparam int unsigned NDIG = WIDTH / 2 + 1;
  localparam int unsigned CW   = cnt_width(NDIG);
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned BW   = WIDTH + 3;
  localparam logic [CW-1:0] LastDig = CW'(NDIG - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Accumulator and shifted multiplicand are kept at 2*WIDTH: the two extra
  // extension bits of the full-width sum never reach out_prod.
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] mcand_q, mcand_d;
  // {B_ext, 1'b0}; shifted right arithmetically by two per retired digit.
  logic [BW-1:0] mplr_q, mplr_d;

  logic [BW-1:0] mplr_shift;
  logic [PW-1:0] pp;
  logic          pp_cin;
  logic          rest_zero;
  logic          sa, sb;

  booth_r4_digit_sel #(
    .PW(PW)
  ) u_digit_sel (
    .bits_i (mplr_q[2:0]),
    .mcand_i(mcand_q),
    .pp_o   (pp),
    .cin_o  (pp_cin)
  );

  assign mplr_shift = {{2{mplr_q[BW-1]}}, mplr_q[BW-1:2]};

`ifdef MUL_EARLY_TERM_EN
  // All-equal remaining multiplier bits encode only zero digits.
  assign rest_zero = (&mplr_shift) | ~(|mplr_shift);
`else
  assign rest_zero = 1'b0;
`endif

  assign sa = op_signed & src_a[WIDTH-1];
  assign sb = op_signed & src_b[WIDTH-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && !flush) begin
          mcand_d = {{WIDTH{sa}}, src_a};
          mplr_d  = {sb, sb, src_b, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d   = acc_q + pp + {{(PW-1){1'b0}}, pp_cin};
        mcand_d = {mcand_q[PW-3:0], 2'b00};
        mplr_d  = mplr_shift;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastDig || rest_zero) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_prod  = out_valid ? acc_q : '0;

endmodule

// File: tb/tb_booth_r4_mul_iter.sv
// Directed self-checking bench for booth_r4_mul_iter (WIDTH = 32), plus a short
// random signed/unsigned sweep against a behavioural product.
module tb_booth_r4_mul_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        op_signed;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_prod;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  booth_r4_mul_iter #(
    .WIDTH(32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_signed(op_signed),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_prod (out_prod),
    .busy     (busy)
  );

`ifdef MUL_EARLY_TERM_EN
  localparam int LatFull = 0;
  localparam int Lat76   = 3;
  localparam int Lat50   = 2;
`else
  localparam int LatFull = 18;
  localparam int Lat76   = 18;
  localparam int Lat50   = 18;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Accept one op at the next negedge; returns with the bench in cycle 1.
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check("in_ready_before_issue", {63'd0, in_ready}, 64'd1);
    in_valid  = 1'b1;
    op_signed = sgn;
    src_a     = a;
    src_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
    src_a    = '1;
    src_b    = '1;
  endtask

  // Waits for out_valid; cyc is the cycle number relative to the accept cycle.
  task automatic wait_done(input string tag, output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat);
    int cyc;
    issue(sgn, a, b);
    wait_done(tag, cyc);
    check(tag, out_prod, exp);
    if (lat != 0) check({tag, "_lat"}, 64'(cyc), 64'(lat));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle"}, {62'd0, in_ready, out_valid}, 64'b10);
  endtask

  initial begin
    int  cyc;
    logic seen;
    logic [63:0] ea, eb, ref_p;
    reset = 1'b1; in_valid = 1'b0; op_signed = 1'b0; src_a = '0; src_b = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_outs", {60'd0, in_ready, out_valid, busy, 1'b0}, {60'd0, 4'b1000});
    check("reset_prod", out_prod, 64'd0);

    run_op("u_ones",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, LatFull);
    run_op("s_ones",   1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, LatFull);
    run_op("s_minmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);
    run_op("s_min_1",  1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, 0);
    run_op("u_7x6",    1'b0, 32'd7, 32'd6, 64'h2A, Lat76);
    run_op("u_5x0",    1'b0, 32'd5, 32'd0, 64'h0, Lat50);
    run_op("u_0xones", 1'b0, 32'd0, 32'hFFFF_FFFF, 64'h0, 0);
    run_op("s_m2x3",   1'b1, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 0);
    run_op("u_msb_x2", 1'b0, 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 0);
    run_op("s_x_m1",   1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 64'hFFFF_FFFF_EDCB_A988, 0);

    // Backpressure: result and status hold while out_ready is low.
    issue(1'b0, 32'd3, 32'd4);
    wait_done("bp", cyc);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_prod", out_prod, 64'd12);
      check("bp_status", {61'd0, out_valid, in_ready, busy}, 64'b101);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release", {62'd0, in_ready, busy}, 64'b10);

    // Flush in CALC cycle 5.
    issue(1'b0, 32'd9, 32'd9);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_calc", {62'd0, in_ready, out_valid}, 64'b10);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_valid", {63'd0, seen}, 64'd0);
    run_op("after_flush", 1'b0, 32'd3, 32'd5, 64'd15, LatFull);

    // Flush in DONE drops the held result.
    issue(1'b1, 32'hFFFF_FFF0, 32'd2);
    wait_done("flush_done", cyc);
    check("flush_done_prod", out_prod, 64'hFFFF_FFFF_FFFF_FFE0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_done_drop", {61'd0, out_valid, in_ready, busy}, 64'b010);
    check("flush_done_prod0", out_prod, 64'd0);

    // flush together with in_valid in IDLE: not accepted.
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; src_a = 32'd2; src_b = 32'd2;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_vs_accept", {62'd0, in_ready, busy}, 64'b10);

    // Reset mid-CALC.
    issue(1'b0, 32'd11, 32'd13);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_mid", {61'd0, in_ready, out_valid, busy}, 64'b100);
    check("reset_mid_prod", out_prod, 64'd0);
    run_op("after_reset", 1'b0, 32'd11, 32'd13, 64'd143, LatFull);

    // Random sweep against a behavioural product.
    for (int k = 0; k < 200; k++) begin
      logic [31:0] ra, rb;
      logic        rs;
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      if (k % 8 == 0) rb = 32'($urandom_range(0, 15));
      ea = rs ? {{32{ra[31]}}, ra} : {32'd0, ra};
      eb = rs ? {{32{rb[31]}}, rb} : {32'd0, rb};
      ref_p = ea * eb;
      run_op("rand", rs, ra, rb, ref_p, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
